// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state encoding and the address/data width.
package mem_port_arbiter_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_sel.sv
// Selects the memory-port command (addr/wdata/be/we) of the granted stage.
// grant_d=1 selects the data port; the fetch side carries zero we/be/wdata.
module mem_port_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic            grant_d,
   input  logic [XLEN-1:0] if_addr,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_be,
   input  logic            d_we,
   output logic [XLEN-1:0] sel_addr,
   output logic [XLEN-1:0] sel_wdata,
   output logic [3:0]      sel_be,
   output logic            sel_we
);

   localparam int unsigned W = 2 * XLEN + 5;

   logic [W-1:0] port_i;
   logic [W-1:0] port_d;
   logic [W-1:0] port_y;

   assign port_i = {if_addr, {XLEN{1'b0}}, 4'b0000, 1'b0};
   assign port_d = {d_addr, d_wdata, d_be, d_we};

   for (genvar g = 0; g < W; g++) begin : g_bit
      mux2x1 u_mux (
         .a0  (port_i[g]),
         .a1  (port_d[g]),
         .sel (grant_d),
         .y   (port_y[g])
      );
   end

   assign {sel_addr, sel_wdata, sel_be, sel_we} = port_y;

endmodule

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer cell; sel=1 passes a1.
module mux2x1 (
   input  logic a0,
   input  logic a1,
   input  logic sel,
   output logic y
);

   assign y = sel ? a1 : a0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between the fetch and load/store stages.
// state  | meaning
// IDLE   | port free; may issue this cycle (data first unless fetch starved)
// WAIT_I | fetch in flight; completes when cnt reaches LATENCY
// WAIT_D | load/store in flight; completes when cnt reaches LATENCY
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LATENCY        = 2,
   parameter int MAX_DATA_BURST = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic [XLEN-1:0] if_rdata,
   output logic            if_valid,
   output logic            if_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [3:0]      d_be,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_valid,
   output logic            d_stall,
   output logic            mem_en,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam int BW = $clog2(MAX_DATA_BURST + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(LATENCY);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

   arb_state_e      state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [BW-1:0]   bcnt, bcnt_nxt;
   logic            grant_d, grant_i;
   logic            done_i, done_d;

   logic [XLEN-1:0] sel_addr;
   logic [XLEN-1:0] sel_wdata;
   logic [3:0]      sel_be;
   logic            sel_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bcnt_nxt  = bcnt;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      done_i    = 1'b0;
      done_d    = 1'b0;
      case (state)
         IDLE: begin
            // Data has priority until MAX_DATA_BURST grants have passed a waiting fetch.
            grant_d = d_req & (~if_req | (bcnt < BURST_MAX));
            grant_i = ~grant_d & if_req;
            if (grant_d) begin
               state_nxt = WAIT_D;
               cnt_nxt   = CW'(1);
               if (!if_req)
                  bcnt_nxt = '0;
               else if (bcnt != BURST_MAX)
                  bcnt_nxt = bcnt + 1'b1;
            end else if (grant_i) begin
               state_nxt = WAIT_I;
               cnt_nxt   = CW'(1);
               bcnt_nxt  = '0;
            end
         end
         WAIT_I, WAIT_D: begin
            if (cnt == CNT_LAST) begin
               done_i    = (state == WAIT_I);
               done_d    = (state == WAIT_D);
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Loads never present byte enables to the memory.
   mem_port_sel u_sel (
      .grant_d   (grant_d),
      .if_addr   (if_addr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be & {4{d_we}}),
      .d_we      (d_we),
      .sel_addr  (sel_addr),
      .sel_wdata (sel_wdata),
      .sel_be    (sel_be),
      .sel_we    (sel_we)
   );

   assign mem_en    = ~rst & (grant_d | grant_i);
   assign mem_we    = mem_en & sel_we;
   assign mem_be    = {4{mem_en}} & sel_be;
   assign mem_addr  = {XLEN{mem_en}} & sel_addr;
   assign mem_wdata = {XLEN{mem_en}} & sel_wdata;

   assign if_valid  = ~rst & done_i;
   assign d_valid   = ~rst & done_d;
   assign if_rdata  = {XLEN{if_valid}} & mem_rdata;
   assign d_rdata   = {XLEN{d_valid}} & mem_rdata;
   assign if_stall  = ~rst & if_req & ~if_valid;
   assign d_stall   = ~rst & d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed sequences and
// a randomized run against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int MAXB = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [3:0]  d_be;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_en, mem_we;
   logic [3:0]  mem_be;

   // second instance with single-cycle memory latency
   logic        if2_req;
   logic [31:0] if2_addr, mem2_rdata;
   logic        d2_req = 1'b0, d2_we = 1'b0;
   logic [3:0]  d2_be = 4'h0;
   logic [31:0] d2_addr = 32'h0, d2_wdata = 32'h0;
   logic [31:0] if2_rdata, d2_rdata, mem2_addr, mem2_wdata;
   logic        if2_valid, if2_stall, d2_valid, d2_stall, mem2_en, mem2_we;
   logic [3:0]  mem2_be;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LATENCY(LAT), .MAX_DATA_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.LATENCY(1), .MAX_DATA_BURST(MAXB)) dut_l1 (
      .clk(clk), .rst(rst),
      .if_req(if2_req), .if_addr(if2_addr), .if_rdata(if2_rdata), .if_valid(if2_valid), .if_stall(if2_stall),
      .d_req(d2_req), .d_we(d2_we), .d_be(d2_be), .d_addr(d2_addr), .d_wdata(d2_wdata),
      .d_rdata(d2_rdata), .d_valid(d2_valid), .d_stall(d2_stall),
      .mem_en(mem2_en), .mem_we(mem2_we), .mem_be(mem2_be), .mem_addr(mem2_addr),
      .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata)
   );

   typedef struct {
      logic        if_req, d_req, d_we;
      logic [3:0]  d_be;
      logic [31:0] if_addr, d_addr, d_wdata;
      logic        exp_en, exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr, exp_wdata;
      int          exp_port;   // 0 none, 1 fetch, 2 data
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a * 32'd40503);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
   endtask

   // leaves the bench at the drive point of the first cycle with rst low
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int          done_cyc, burst, inf_port;
      logic        inf_we, ifv, dv, e_en, e_we, e_ifv, e_dv;
      logic [3:0]  e_be;
      logic [31:0] inf_addr, e_addr, e_wdata;

      vecs[0] = '{if_req:1, d_req:0, d_we:0, d_be:4'h0, if_addr:32'h10, d_addr:32'h0, d_wdata:32'h0,
                  exp_en:1, exp_we:0, exp_be:4'h0, exp_addr:32'h10, exp_wdata:32'h0, exp_port:1};
      vecs[1] = '{if_req:0, d_req:1, d_we:0, d_be:4'hF, if_addr:32'h0, d_addr:32'h200, d_wdata:32'h12345678,
                  exp_en:1, exp_we:0, exp_be:4'h0, exp_addr:32'h200, exp_wdata:32'h12345678, exp_port:2};
      vecs[2] = '{if_req:0, d_req:1, d_we:1, d_be:4'h3, if_addr:32'h0, d_addr:32'h100, d_wdata:32'hDEADBEEF,
                  exp_en:1, exp_we:1, exp_be:4'h3, exp_addr:32'h100, exp_wdata:32'hDEADBEEF, exp_port:2};
      vecs[3] = '{if_req:1, d_req:1, d_we:0, d_be:4'h0, if_addr:32'h10, d_addr:32'h300, d_wdata:32'h0,
                  exp_en:1, exp_we:0, exp_be:4'h0, exp_addr:32'h300, exp_wdata:32'h0, exp_port:2};
      vecs[4] = '{if_req:0, d_req:0, d_we:1, d_be:4'hF, if_addr:32'h80, d_addr:32'h90, d_wdata:32'hFFFF,
                  exp_en:0, exp_we:0, exp_be:4'h0, exp_addr:32'h0, exp_wdata:32'h0, exp_port:0};
      vecs[5] = '{if_req:1, d_req:1, d_we:1, d_be:4'hF, if_addr:32'h44, d_addr:32'h104, d_wdata:32'h0BADF00D,
                  exp_en:1, exp_we:1, exp_be:4'hF, exp_addr:32'h104, exp_wdata:32'h0BADF00D, exp_port:2};

      if2_req = 0; if2_addr = 0; mem2_rdata = 0; mem_rdata = 0;

      // everything quiet while reset is held, even with both requests up
      rst = 1'b1;
      if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 1; d_be = 4'hF;
      d_addr = 32'h100; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we_be", {27'd0, mem_we, mem_be}, 0);
      chk("rst_stalls", {30'd0, if_stall, d_stall}, 0);
      chk("rst_valids", {30'd0, if_valid, d_valid}, 0);
      chk("rst_mem2_en", 32'(mem2_en), 0);

      // table-driven single transactions from a fresh reset
      for (int i = 0; i < 6; i++) begin
         do_reset();
         if_req = vecs[i].if_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be;
         if_addr = vecs[i].if_addr; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
         mem_rdata = 32'h00500093;
         @(negedge clk);
         chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_en));
         chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
         chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
         chk($sformatf("v%0d_if_stall0", i), 32'(if_stall), 32'(vecs[i].if_req));
         chk($sformatf("v%0d_d_stall0", i), 32'(d_stall), 32'(vecs[i].d_req));
         next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_cyc1_quiet", i), {29'd0, mem_en, if_valid, d_valid}, 0);
         chk($sformatf("v%0d_cyc1_rdata", i), if_rdata | d_rdata, 0);
         next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].exp_port == 1));
         chk($sformatf("v%0d_d_valid", i), 32'(d_valid), 32'(vecs[i].exp_port == 2));
         chk($sformatf("v%0d_if_rdata", i), if_rdata, (vecs[i].exp_port == 1) ? 32'h00500093 : 32'h0);
         if (vecs[i].exp_port == 2 && !vecs[i].d_we)
            chk($sformatf("v%0d_d_rdata", i), d_rdata, 32'h00500093);
         chk($sformatf("v%0d_if_stall2", i), 32'(if_stall),
             32'(vecs[i].if_req && vecs[i].exp_port != 1));
         chk($sformatf("v%0d_d_stall2", i), 32'(d_stall), 0);
         next_cycle();
         idle_inputs();
      end

      // simultaneous load and fetch: data first, fetch issued right after completion
      do_reset();
      if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h200;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) d_req = 0;
         if (c == 6) if_req = 0;
         mem_rdata = (c == 2) ? 32'h1111_2222 : (c == 5) ? 32'h00500093 : 32'hFFFF_0000 + 32'(c);
         @(negedge clk);
         chk($sformatf("sim_c%0d_mem_en", c), 32'(mem_en), 32'(c == 0 || c == 3));
         chk($sformatf("sim_c%0d_mem_addr", c), mem_addr,
             (c == 0) ? 32'h200 : (c == 3) ? 32'h10 : 32'h0);
         chk($sformatf("sim_c%0d_valids", c), {30'd0, if_valid, d_valid},
             {30'd0, c == 5, c == 2});
         chk($sformatf("sim_c%0d_stalls", c), {30'd0, if_stall, d_stall},
             {30'd0, c < 5, c < 2});
         if (c == 2) chk("sim_d_rdata", d_rdata, 32'h1111_2222);
         if (c == 5) chk("sim_if_rdata", if_rdata, 32'h00500093);
         next_cycle();
      end
      idle_inputs();

      // both held: D,D,I repeating, one issue every LAT+1 cycles
      do_reset();
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80; mem_rdata = 32'h0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         chk($sformatf("burst_c%0d_mem_en", c), 32'(mem_en), 32'(c % 3 == 0));
         chk($sformatf("burst_c%0d_mem_addr", c), mem_addr,
             (c % 3 != 0) ? 32'h0 : ((c / 3) % 3 == 2) ? 32'h40 : 32'h80);
         next_cycle();
      end
      idle_inputs();

      // reset during a fetch: abandoned, re-issued once reset drops
      do_reset();
      if_req = 1; if_addr = 32'h10; mem_rdata = 32'h00500093;
      @(negedge clk);
      chk("rstmid_issue", 32'(mem_en), 1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_c1_outs", {28'd0, mem_en, if_valid, if_stall, d_stall}, 0);
      chk("rstmid_c1_addr", mem_addr, 0);
      next_cycle();
      @(negedge clk);
      chk("rstmid_c2_valid", {31'd0, if_valid}, 0);
      chk("rstmid_c2_rdata", if_rdata, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_reissue_en", 32'(mem_en), 1);
      chk("rstmid_reissue_addr", mem_addr, 32'h10);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rstmid_valid", 32'(if_valid), 1);
      chk("rstmid_rdata", if_rdata, 32'h00500093);
      next_cycle();
      idle_inputs();

      // LATENCY=1 instance, continuous fetches
      if2_req = 1; if2_addr = 32'h20; mem2_rdata = 32'hCAFEF00D;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("l1_c%0d_mem_en", c), 32'(mem2_en), 32'(c % 2 == 0));
         chk($sformatf("l1_c%0d_mem_addr", c), mem2_addr, (c % 2 == 0) ? 32'h20 : 32'h0);
         chk($sformatf("l1_c%0d_valid", c), 32'(if2_valid), 32'(c % 2 == 1));
         chk($sformatf("l1_c%0d_rdata", c), if2_rdata, (c % 2 == 1) ? 32'hCAFEF00D : 32'h0);
         next_cycle();
      end
      if2_req = 0;

      // randomized traffic against a transaction-level model
      do_reset();
      done_cyc = -1; burst = 0; inf_port = 0; inf_we = 0; inf_addr = 0;
      ifv = 0; dv = 0;
      for (int c = 0; c < 2000; c++) begin
         if (ifv) if_req = 0;
         if (!if_req && $urandom_range(0, 2) != 0) begin
            if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (dv) d_req = 0;
         if (!d_req && $urandom_range(0, 2) != 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end
         mem_rdata = (c == done_cyc) ? memf(inf_addr) : $urandom;
         @(negedge clk);
         e_en = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_ifv = 0; e_dv = 0;
         if (c <= done_cyc) begin
            if (c == done_cyc) begin
               e_ifv = (inf_port == 1);
               e_dv  = (inf_port == 2);
            end
         end else if (d_req && (!if_req || burst < MAXB)) begin
            e_en = 1; e_we = d_we; e_be = d_we ? d_be : 4'h0; e_addr = d_addr; e_wdata = d_wdata;
            burst = if_req ? ((burst < MAXB) ? burst + 1 : MAXB) : 0;
            done_cyc = c + LAT; inf_port = 2; inf_we = d_we; inf_addr = d_addr;
         end else if (if_req) begin
            e_en = 1; e_addr = if_addr;
            burst = 0;
            done_cyc = c + LAT; inf_port = 1; inf_we = 0; inf_addr = if_addr;
         end
         chk("rnd_mem_en", 32'(mem_en), 32'(e_en));
         chk("rnd_mem_addr", mem_addr, e_addr);
         chk("rnd_mem_we_be", {27'd0, mem_we, mem_be}, {27'd0, e_we, e_be});
         chk("rnd_mem_wdata", mem_wdata, e_wdata);
         chk("rnd_valids", {30'd0, if_valid, d_valid}, {30'd0, e_ifv, e_dv});
         chk("rnd_if_rdata", if_rdata, e_ifv ? memf(inf_addr) : 32'h0);
         if (!e_dv || !inf_we)
            chk("rnd_d_rdata", d_rdata, e_dv ? memf(inf_addr) : 32'h0);
         chk("rnd_stalls", {30'd0, if_stall, d_stall}, {30'd0, if_req & ~e_ifv, d_req & ~e_dv});
         ifv = e_ifv;
         dv  = e_dv;
         next_cycle();
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
